// File: rtl/frame_sink_if.sv
// rtl/frame_sink_if.sv - APB config bus and stream input bundle for frame_sink
//
// Groups the frame_sink register-bus and stream signals.
//   cfg_*   : APB slave (paddr/pwrite/pwdata/psel/penable in, pready/prdata/pslverr out)
//   cfg_irq : latched end-of-frame interrupt
//   din_*   : stream input (valid/data/eof in, ready out)
// master: the side driving APB requests and stream beats; slave: frame_sink.
interface frame_sink_if #(
  parameter int DataBits = 8
);
  logic [5:0]          cfg_paddr;
  logic                cfg_pwrite;
  logic [31:0]         cfg_pwdata;
  logic                cfg_psel;
  logic                cfg_penable;
  logic                cfg_pready;
  logic [31:0]         cfg_prdata;
  logic                cfg_pslverr;
  logic                cfg_irq;
  logic                din_valid;
  logic                din_ready;
  logic [DataBits-1:0] din_data;
  logic                din_eof;

  modport master (
    output cfg_paddr, cfg_pwrite, cfg_pwdata, cfg_psel, cfg_penable,
    input  cfg_pready, cfg_prdata, cfg_pslverr, cfg_irq,
    output din_valid, din_data, din_eof,
    input  din_ready
  );

  modport slave (
    input  cfg_paddr, cfg_pwrite, cfg_pwdata, cfg_psel, cfg_penable,
    output cfg_pready, cfg_prdata, cfg_pslverr, cfg_irq,
    input  din_valid, din_data, din_eof,
    output din_ready
  );
endinterface

// File: rtl/frame_sink.sv
// rtl/frame_sink.sv - stream sink checking frame checksum, length and counter pattern
//
// Consumes frames from the frame generator, accumulates a 32-bit checksum and
// length per frame, checks each beat against the generator counter pattern and
// reports results through APB registers plus a latched end-of-frame IRQ.
// Ports: clk, rst (async, active high), bus (frame_sink_if.slave: cfg_* APB,
//        cfg_irq, din_* stream).
// Optional: define FRAME_SINK_THROTTLE_EN to enable periodic backpressure via
//           the Throttle register.
module frame_sink #(
  parameter int DataBits      = 8,
  parameter int ExpLenDefault = 2230
) (
  input  logic          clk,
  input  logic          rst,
  frame_sink_if.slave   bus
);
  typedef enum logic {WAIT_FIRST, IN_FRAME} state_t;

  state_t              state_q, state_d;
  logic [15:0]         pos_q, pos_d;
  logic [31:0]         acc_q, acc_d;
  logic [DataBits-1:0] pred_q, pred_d;
  logic [31:0]         csum_q, csum_d;
  logic [16:0]         last_len_q, last_len_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         data_err_q, data_err_d;
  logic [15:0]         exp_len_q, exp_len_d;
  logic [15:0]         len_err_q, len_err_d;
  logic                irq_q, irq_d;
  logic                ready_q, ready_d;
  logic [31:0]         prdata_q, prdata_d;
  logic [15:0]         thr_q, thr_d;
  logic [15:0]         thr_cnt_q, thr_cnt_d;

  logic                setup, wr, rd, beat, first;
  logic [3:0]          waddr;
  logic [DataBits-1:0] expected, step;
  logic [31:0]         sum;
  logic [16:0]         beat_len;
  logic                unused_ok;

  assign setup    = bus.cfg_psel & ~bus.cfg_penable;
  assign wr       = setup & bus.cfg_pwrite;
  assign rd       = setup & ~bus.cfg_pwrite;
  assign waddr    = bus.cfg_paddr[5:2];
  assign beat     = bus.din_valid & ready_q;
  assign first    = (state_q == WAIT_FIRST);
  // Frame n follows a counter starting at n with stride n+1; the prediction
  // advances from expected values so a single bad word costs one error.
  assign step     = DataBits'(frame_cnt_q) + DataBits'(1);
  assign expected = first ? DataBits'(frame_cnt_q) : pred_q;
  assign sum      = (first ? 32'd0 : acc_q) + 32'(bus.din_data);
  assign beat_len = {1'b0, pos_q} + 17'd1;

  assign bus.cfg_pready  = 1'b1;
  assign bus.cfg_pslverr = 1'b0;
  assign bus.cfg_prdata  = prdata_q;
  assign bus.cfg_irq     = irq_q;
  assign bus.din_ready   = ready_q;
  assign unused_ok       = ^{bus.cfg_paddr[1:0], bus.cfg_pwdata[31:16]};

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    acc_d       = acc_q;
    pred_d      = pred_q;
    csum_d      = csum_q;
    last_len_d  = last_len_q;
    frame_cnt_d = frame_cnt_q;
    data_err_d  = data_err_q;
    exp_len_d   = exp_len_q;
    len_err_d   = len_err_q;
    irq_d       = irq_q;
    prdata_d    = prdata_q;
    thr_d       = thr_q;
    thr_cnt_d   = thr_cnt_q;
    ready_d     = 1'b1;

`ifdef FRAME_SINK_THROTTLE_EN
    // Counter cycles 0..t; ready is dropped for the cycle after it reaches t.
    thr_cnt_d = (thr_cnt_q == thr_q) ? 16'd0 : thr_cnt_q + 16'd1;
    ready_d   = !((thr_q != 16'd0) && (thr_cnt_q == thr_q));
`endif

    if (beat) begin
      if ((bus.din_data != expected) && (data_err_q != 16'hFFFF))
        data_err_d = data_err_q + 16'd1;
      if (bus.din_eof) begin
        state_d     = WAIT_FIRST;
        pos_d       = 16'd0;
        acc_d       = 32'd0;
        csum_d      = sum;
        last_len_d  = beat_len;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if ((beat_len != {1'b0, exp_len_q}) && (len_err_q != 16'hFFFF))
          len_err_d = len_err_q + 16'd1;
      end else begin
        state_d = IN_FRAME;
        if (pos_q != 16'hFFFF)
          pos_d = pos_q + 16'd1;
        acc_d  = sum;
        pred_d = expected + step;
      end
    end

    if (wr) begin
      case (waddr)
        4'd5: exp_len_d = bus.cfg_pwdata[15:0];
`ifdef FRAME_SINK_THROTTLE_EN
        4'd7: begin
          thr_d     = bus.cfg_pwdata[15:0];
          thr_cnt_d = 16'd0;
        end
`endif
        4'd8: irq_d = bus.cfg_pwdata[0];
        4'd9: if (bus.cfg_pwdata[0]) begin
          // Applied after the beat update so Clear wins over a same-cycle eof.
          data_err_d  = 16'd0;
          len_err_d   = 16'd0;
          frame_cnt_d = 16'd0;
          csum_d      = 32'd0;
          last_len_d  = 17'd0;
        end
        default: ;
      endcase
    end

    // eof sets the IRQ even when a clearing write lands in the same cycle.
    if (beat && bus.din_eof)
      irq_d = 1'b1;

    if (rd) begin
      case (waddr)
        4'd0: prdata_d = {29'd0, (state_q == IN_FRAME), ready_q, bus.din_valid};
        4'd1: prdata_d = csum_q;
        4'd2: prdata_d = {15'd0, last_len_q};
        4'd3: prdata_d = {16'd0, frame_cnt_q};
        4'd4: prdata_d = {16'd0, data_err_q};
        4'd5: prdata_d = {16'd0, exp_len_q};
        4'd6: prdata_d = {16'd0, len_err_q};
        4'd7: prdata_d = {16'd0, thr_q};
        4'd8: prdata_d = {31'd0, irq_q};
        4'd9: prdata_d = 32'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_FIRST;
      pos_q       <= 16'd0;
      acc_q       <= 32'd0;
      pred_q      <= '0;
      csum_q      <= 32'd0;
      last_len_q  <= 17'd0;
      frame_cnt_q <= 16'd0;
      data_err_q  <= 16'd0;
      exp_len_q   <= 16'(ExpLenDefault);
      len_err_q   <= 16'd0;
      irq_q       <= 1'b0;
      ready_q     <= 1'b0;
      prdata_q    <= 32'd0;
      thr_q       <= 16'd0;
      thr_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      acc_q       <= acc_d;
      pred_q      <= pred_d;
      csum_q      <= csum_d;
      last_len_q  <= last_len_d;
      frame_cnt_q <= frame_cnt_d;
      data_err_q  <= data_err_d;
      exp_len_q   <= exp_len_d;
      len_err_q   <= len_err_d;
      irq_q       <= irq_d;
      ready_q     <= ready_d;
      prdata_q    <= prdata_d;
      thr_q       <= thr_d;
      thr_cnt_q   <= thr_cnt_d;
    end
  end
endmodule

// File: tb/tb_frame_sink.sv
// tb/tb_frame_sink.sv - scoreboard testbench for frame_sink
module tb_frame_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  string       exp_names[$];
  logic [31:0] exp_vals[$];

  frame_sink_if #(.DataBits(8)) bus ();

  frame_sink #(.DataBits(8), .ExpLenDefault(2230)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read data is presented during the access phase.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.cfg_psel && bus.cfg_penable && !bus.cfg_pwrite) begin
        if (exp_vals.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_empty: got 0x%0h expected none", bus.cfg_prdata);
        end else begin
          check(exp_names.pop_front(), bus.cfg_prdata, exp_vals.pop_front());
        end
      end
    end
  end

  task automatic apb_read(input int word, input logic [31:0] exp, input string name);
    exp_names.push_back(name);
    exp_vals.push_back(exp);
    bus.cfg_paddr   = 6'(word * 4);
    bus.cfg_pwrite  = 1'b0;
    bus.cfg_psel    = 1'b1;
    bus.cfg_penable = 1'b0;
    @(posedge clk); #1;
    bus.cfg_penable = 1'b1;
    @(posedge clk); #1;
    bus.cfg_psel    = 1'b0;
    bus.cfg_penable = 1'b0;
  endtask

  task automatic apb_setup_wr(input int word, input logic [31:0] data);
    bus.cfg_paddr   = 6'(word * 4);
    bus.cfg_pwrite  = 1'b1;
    bus.cfg_pwdata  = data;
    bus.cfg_psel    = 1'b1;
    bus.cfg_penable = 1'b0;
  endtask

  task automatic apb_access_end();
    bus.cfg_penable = 1'b1;
    @(posedge clk); #1;
    bus.cfg_psel    = 1'b0;
    bus.cfg_penable = 1'b0;
    bus.cfg_pwrite  = 1'b0;
  endtask

  task automatic apb_write(input int word, input logic [31:0] data);
    apb_setup_wr(word, data);
    @(posedge clk); #1;
    apb_access_end();
  endtask

  // Drive one beat and hold it until accepted; ends #1 after the accepting edge.
  task automatic beat(input logic [7:0] d, input logic e);
    logic r;
    logic ok;
    ok = 1'b0;
    bus.din_valid = 1'b1;
    bus.din_data  = d;
    bus.din_eof   = e;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = bus.din_ready;
      @(posedge clk);
      if (r) ok = 1'b1;
    end
    #1;
    bus.din_valid = 1'b0;
    bus.din_eof   = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: got no accept expected accept");
    end
  endtask

  task automatic frame4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    beat(a, 1'b0);
    beat(b, 1'b0);
    beat(c, 1'b0);
    beat(d, 1'b1);
  endtask

  initial begin
    int t0;
    int lows;
    bus.cfg_paddr   = '0;
    bus.cfg_pwrite  = 1'b0;
    bus.cfg_pwdata  = '0;
    bus.cfg_psel    = 1'b0;
    bus.cfg_penable = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din_data    = '0;
    bus.din_eof     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.din_ready), 32'd0);
    check("rst_irq", 32'(bus.cfg_irq), 32'd0);
    check("rst_prdata", bus.cfg_prdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    apb_read(0, 32'd2, "status_idle");
    apb_read(5, 32'd2230, "explen_reset");
    apb_read(12, 32'd2230, "unmapped_keeps");
    apb_write(7, 32'd5);
`ifdef FRAME_SINK_THROTTLE_EN
    apb_read(7, 32'd5, "throttle_rw");
    apb_write(7, 32'd0);
`else
    apb_read(7, 32'd0, "throttle_disabled");
`endif
    apb_write(5, 32'd4);
    apb_read(5, 32'd4, "explen_rw");

    // Frame 0: 0,1,2,3 with a status read mid-frame.
    beat(8'd0, 1'b0);
    apb_read(0, 32'd6, "status_inframe");
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b1);
    check("f0_irq", 32'(bus.cfg_irq), 32'd1);
    apb_read(1, 32'd6, "f0_csum");
    apb_read(13, 32'd6, "unmapped_after_csum");
    apb_read(2, 32'd4, "f0_lastlen");
    apb_read(3, 32'd1, "f0_fcount");
    apb_read(4, 32'd0, "f0_dataerr");
    apb_read(6, 32'd0, "f0_lenerr");
    apb_read(8, 32'd1, "f0_irqreg");

    // Frame 1: stride 2.
    frame4(8'd1, 8'd3, 8'd5, 8'd7);
    apb_read(1, 32'd16, "f1_csum");
    apb_read(4, 32'd0, "f1_dataerr");
    apb_write(8, 32'd0);
    check("irq_cleared", 32'(bus.cfg_irq), 32'd0);

    // Frame 2: irq clear collides with eof; set wins.
    beat(8'd2, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd8, 1'b0);
    apb_setup_wr(8, 32'd0);
    beat(8'd11, 1'b1);
    apb_access_end();
    check("irq_set_wins", 32'(bus.cfg_irq), 32'd1);
    apb_read(1, 32'd26, "f2_csum");
    apb_read(3, 32'd3, "f2_fcount");
    apb_read(4, 32'd0, "f2_dataerr");

    // Single corrupted word after Clear.
    apb_write(9, 32'd1);
    apb_read(3, 32'd0, "clr_fcount");
    frame4(8'd0, 8'd9, 8'd2, 8'd3);
    apb_read(4, 32'd1, "corrupt_dataerr");
    apb_read(1, 32'd14, "corrupt_csum");

    // Five-beat frame against ExpLen=4.
    apb_write(9, 32'd1);
    apb_read(4, 32'd0, "clr_dataerr");
    beat(8'd0, 1'b0);
    frame4(8'd1, 8'd2, 8'd3, 8'd4);
    apb_read(6, 32'd1, "long_lenerr");
    apb_read(2, 32'd5, "long_lastlen");
    apb_read(1, 32'd10, "long_csum");
    apb_write(9, 32'd1);
    apb_read(6, 32'd0, "clr_lenerr");
    apb_read(3, 32'd0, "clr_fcount2");
    apb_read(1, 32'd0, "clr_csum");
    apb_read(2, 32'd0, "clr_lastlen");

    // Reset in the middle of a frame.
    apb_write(3 + 6, 32'd0);
    frame4(8'd0, 8'd1, 8'd2, 8'd3);
    beat(8'd1, 1'b0);
    beat(8'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(bus.din_ready), 32'd0);
    check("midrst_irq", 32'(bus.cfg_irq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apb_read(3, 32'd0, "midrst_fcount");
    apb_read(5, 32'd2230, "midrst_explen");
    apb_write(5, 32'd4);
    frame4(8'd0, 8'd1, 8'd2, 8'd3);
    apb_read(3, 32'd1, "post_fcount");
    apb_read(1, 32'd6, "post_csum");
    apb_read(4, 32'd0, "post_dataerr");

    // Single-beat frame, n=1.
    beat(8'd1, 1'b1);
    apb_read(2, 32'd1, "single_lastlen");
    apb_read(1, 32'd1, "single_csum");
    apb_read(6, 32'd1, "single_lenerr");
    apb_read(4, 32'd0, "single_dataerr");

`ifdef FRAME_SINK_THROTTLE_EN
    apb_write(7, 32'd3);
    bus.din_valid = 1'b0;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.din_ready) lows++;
    end
    check("throttle_lows", 32'(lows), 32'd2);
    @(posedge clk); #1;
    t0 = cyc;
    frame4(8'd2, 8'd5, 8'd8, 8'd11);
    check("throttle_cycles", 32'(cyc - t0), 32'd5);
    apb_read(4, 32'd0, "throttle_dataerr");
    apb_read(1, 32'd26, "throttle_csum");
    apb_write(7, 32'd0);
`else
    lows = 0;
    t0 = 0;
`endif

    for (int i = 0; i < 50 && exp_vals.size() != 0; i++) @(posedge clk);
    if (exp_vals.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_vals.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
